spi_byte_rx: RTL
================

// Module: spi_byte_rx
// PURPOSE
//   SPI mode-0 slave receiver for the Raspberry Pi link. It sits directly downstream of the
//   raw SPI pins (pi_spi_sclk/mosi/cs_n), in the position the pin-test probe occupies today.
//   It synchronizes the pins, frames transfers on CS, and assembles MSB-first bytes.
//   Bytes go into a small FIFO with a valid/ready output toward the command decoder.
// PARAMETERS
//   SYNC_STAGES  2  flops per pin synchronizer (>=2)
//   FIFO_DEPTH   4  byte FIFO entries (power of 2, >=2)
// PORTS
//   clk           in   1  system clock; every flop is on its rising edge
//   reset_n       in   1  asynchronous, active-low reset
//   pi_spi_sclk   in   1  SPI clock from Pi, asynchronous; idles low (CPOL=0)
//   pi_spi_mosi   in   1  SPI data from Pi, asynchronous; sampled on SCLK rise (CPHA=0)
//   pi_spi_cs_n   in   1  SPI chip select, active low, asynchronous
//   rx_data       out  8  FIFO head byte; valid only while rx_valid=1
//   rx_valid      out  1  FIFO not empty
//   rx_ready      in   1  consumer accepts head when rx_valid&&rx_ready
//   frame_active  out  1  CS currently asserted (synchronized view)
//   frame_done    out  1  1-cycle pulse on CS deassert
//   frame_bytes   out  8  complete bytes in current/last frame; saturates at 255
//   overflow      out  1  sticky: a complete byte was dropped because the FIFO was full
//   clear_ovf     in   1  clears overflow
// BEHAVIOUR
//   Reset values: sync chains sclk=0, mosi=0, cs_n=1; sclk_prev=0; cs_prev=0; rx_valid=0;
//     rx_data=0; frame_active=0; frame_done=0; frame_bytes=0; overflow=0; FIFO empty.
//   Edge detect: s_* = last sync stage. sclk_rise = s_sclk & ~sclk_prev.
//     cs_fall = cs_prev & ~s_cs_n. cs_rise = ~cs_prev & s_cs_n.
//     cs_prev resets to 0, so a pin already low at reset exit never starts a frame.
//     CS must be seen high first.
//   FSM IDLE -> ACTIVE on cs_fall: bit_cnt<=0, shift<=0, frame_bytes<=0, frame_active<=1.
//   In ACTIVE, on sclk_rise: shift<={shift[6:0],s_mosi}, bit_cnt++ (3-bit, wraps 7->0).
//     The rise with bit_cnt==7 completes a byte: byte_done<=1 (registered), byte_q<=new
//     shift value, frame_bytes++ (saturating).
//   ACTIVE -> IDLE on cs_rise: frame_active<=0, frame_done<=1 for one cycle. The partial
//     byte (bit_cnt!=0) is discarded silently. frame_bytes holds until the next cs_fall.
//   Same-cycle sclk_rise and cs_rise in ACTIVE: the bit is shifted and a byte completes if
//     bit_cnt==7. The byte is counted in frame_bytes. The frame then ends.
//   sclk_rise in IDLE is ignored.
//   FIFO write happens when byte_done=1, one cycle after the completing sclk_rise.
//     If full and no pop in that cycle: byte dropped, overflow<=1.
//     Full with a simultaneous pop: the write is accepted.
//     The dropped byte still counts in frame_bytes.
//   FIFO read: pop when rx_valid&&rx_ready. rx_data/rx_valid come from registered FIFO
//     state (no comb path from rx_ready).
//     Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
//   Latency: cycle T = detection of completing sclk_rise; byte_done at T+1; rx_valid=1 at
//     T+2 if FIFO was empty.
//   overflow: set has priority over clear_ovf in the same cycle.
//   Timing: SCLK high and low times each >= SYNC_STAGES+2 clk periods (e.g. SCLK <= clk/8
//     for 2 stages). Faster SCLK is out of spec.
//   Reset mid-frame: all state cleared at once. Reception resumes only after CS high->low.
// TESTING
//   1 Frame: 0xA5 then 0x3C, SCLK=clk/16, rx_ready=1 -> rx_data 0xA5, then 0x3C;
//     frame_done pulses once; frame_bytes=2.
//   2 rx_ready=0, send 5 bytes (DEPTH=4) -> first 4 bytes held in order; overflow=1;
//     frame_bytes=5. clear_ovf -> overflow=0.
//   3 CS rises after 11 bits (0xFF + 3 bits) -> one byte 0xFF out; partial byte dropped;
//     frame_bytes=1. Next frame byte 0x01 decodes correctly.
//   4 SCLK toggling with CS high -> no rx_valid, frame_bytes unchanged, frame_active=0.
//   5 Assert reset_n low after bit 4 of a frame with CS still low -> all outputs at reset
//     values. No bytes until CS high then low; the next full byte decodes correctly.
//   6 FIFO full, byte completes in the same cycle as a pop -> byte accepted, overflow stays 0.

Source files
------------

// File: rtl/spi_byte_rx_if.sv
// Byte stream from the SPI receiver FIFO toward the command decoder.
// The producer drives data/valid; the consumer drives ready.
interface spi_byte_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave receiver: synchronizes the Pi SPI pins, frames transfers on CS,
// assembles MSB-first bytes and buffers them in a small FIFO with valid/ready output.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pi_spi_sclk,
    input  logic          pi_spi_mosi,
    input  logic          pi_spi_cs_n,
    spi_byte_rx_if.master rx,
    output logic          frame_active,
    output logic          frame_done,
    output logic [7:0]    frame_bytes,
    output logic          overflow,
    input  logic          clear_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             byte_q, byte_d;
    logic                   byte_done_q, byte_done_d;
    logic [7:0]             frame_bytes_q, frame_bytes_d;
    logic                   frame_done_q, frame_done_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [7:0]             mem_d [FIFO_DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;

    logic s_sclk, s_mosi, s_cs_n;
    logic sclk_rise, cs_fall, cs_rise;
    logic fifo_full, fifo_empty, push, pop;

    assign s_sclk = sclk_sync_q[SYNC_STAGES-1];
    assign s_mosi = mosi_sync_q[SYNC_STAGES-1];
    assign s_cs_n = cs_sync_q[SYNC_STAGES-1];

    assign sclk_rise = s_sclk & ~sclk_prev_q;
    assign cs_fall   = cs_prev_q & ~s_cs_n;
    assign cs_rise   = ~cs_prev_q & s_cs_n;

    // cs_prev only follows the pin once the chain holds real samples, so a CS held
    // low through reset exit cannot look like a falling edge.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], pi_spi_sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], pi_spi_mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], pi_spi_cs_n};
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
        sclk_prev_d = s_sclk;
        cs_prev_d   = fill_q[SYNC_STAGES-1] & s_cs_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_active = (state_q == ACTIVE);
    end

    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        byte_d        = byte_q;
        byte_done_d   = 1'b0;
        frame_bytes_d = frame_bytes_q;
        frame_done_d  = 1'b0;
        if (state_q == IDLE && cs_fall) begin
            bit_cnt_d     = 3'd0;
            shift_d       = 8'd0;
            frame_bytes_d = 8'd0;
        end
        // A bit arriving together with CS release still counts before the frame closes.
        if (state_q == ACTIVE) begin
            if (sclk_rise) begin
                shift_d   = {shift_q[6:0], s_mosi};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_done_d = 1'b1;
                    byte_d      = {shift_q[6:0], s_mosi};
                    if (frame_bytes_q != 8'hFF) frame_bytes_d = frame_bytes_q + 8'd1;
                end
            end
            if (cs_rise) frame_done_d = 1'b1;
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
    assign push       = byte_done_q;
    assign pop        = ~fifo_empty & rx.rx_ready;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push && (!fifo_full || pop)) begin
            mem_d[wr_ptr_q[AW-1:0]] = byte_q;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (clear_ovf) overflow_d = 1'b0;
        if (push && fifo_full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q   <= '0;
            mosi_sync_q   <= '0;
            cs_sync_q     <= '1;
            fill_q        <= '0;
            sclk_prev_q   <= 1'b0;
            cs_prev_q     <= 1'b0;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'd0;
            byte_q        <= 8'd0;
            byte_done_q   <= 1'b0;
            frame_bytes_q <= 8'd0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'd0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            cs_sync_q     <= cs_sync_d;
            fill_q        <= fill_d;
            sclk_prev_q   <= sclk_prev_d;
            cs_prev_q     <= cs_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            byte_q        <= byte_d;
            byte_done_q   <= byte_done_d;
            frame_bytes_q <= frame_bytes_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_q         <= mem_d;
        end
    end

    assign rx.rx_valid = ~fifo_empty;
    assign rx.rx_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign frame_done  = frame_done_q;
    assign frame_bytes = frame_bytes_q;
    assign overflow    = overflow_q;
endmodule
